edge_detector: RTL and testbench

EDGE_DETECTOR -- requirements
Module: edge_detector

---
 rtl/edge_detector.sv | 38 +++
 tb/tb_edge_detector.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/edge_detector.sv
// Per-bit rising/falling edge detector: compares a_i against the value sampled
// on the previous rising clk and emits same-cycle, single-cycle pulses.
module edge_detector #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a_i,
    output logic [WIDTH-1:0] rising_edge_o,
    output logic [WIDTH-1:0] falling_edge_o
);

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] a_d;

    // History clears on reset so the first post-reset 1 counts as a rising edge.
    always_comb begin
        a_d = a_i;
        if (reset) begin
            a_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        a_q <= a_d;
    end

    // Outputs are combinational (zero latency) and forced low while reset is held.
    always_comb begin
        rising_edge_o  = '0;
        falling_edge_o = '0;
        if (!reset) begin
            rising_edge_o  = a_i & ~a_q;
            falling_edge_o = ~a_i & a_q;
        end
    end

endmodule

// File: tb/tb_edge_detector.sv
// Scoreboard bench for edge_detector (WIDTH = 4): stimulus pushes expected
// pulses computed from a reference model; a monitor pops and compares each cycle.
module tb_edge_detector;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] r;
        logic [W-1:0] f;
        int           id;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] a_i;
    logic [W-1:0] rising_edge_o;
    logic [W-1:0] falling_edge_o;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   step_id = 0;

    // Reference model state: the value the design should have remembered.
    logic [W-1:0] last_a;
    logic         last_rst;
    logic [W-1:0] prev;

    edge_detector #(.WIDTH(W)) dut (
        .clk            (clk),
        .reset          (reset),
        .a_i            (a_i),
        .rising_edge_o  (rising_edge_o),
        .falling_edge_o (falling_edge_o)
    );

    always #5 clk = ~clk;

    // Apply one cycle of stimulus. When use_exp is set, the given constants are
    // the required outputs; otherwise the model's edge rule supplies them.
    task automatic step(input logic rst, input logic [W-1:0] a,
                        input logic use_exp, input logic [W-1:0] er,
                        input logic [W-1:0] ef);
        exp_t e;
        @(posedge clk);
        prev = last_rst ? '0 : last_a;
        #1;
        reset = rst;
        a_i   = a;
        last_rst = rst;
        last_a   = a;
        step_id++;
        e.id = step_id;
        if (use_exp) begin
            e.r = er;
            e.f = ef;
        end else begin
            e.r = '0;
            e.f = '0;
            for (int n = 0; n < W; n++) begin
                if (!rst && a[n] && !prev[n]) e.r[n] = 1'b1;
                if (!rst && !a[n] && prev[n]) e.f[n] = 1'b1;
            end
        end
        sb_q.push_back(e);
    endtask

    task automatic chk(input logic rst, input logic [W-1:0] a,
                       input logic [W-1:0] er, input logic [W-1:0] ef);
        step(rst, a, 1'b1, er, ef);
    endtask

    // Monitor: combinational outputs are valid every cycle; sample on negedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++;
                if (rising_edge_o !== e.r) begin
                    errors++;
                    $display("FAIL rise step %0d: got %b expected %b", e.id, rising_edge_o, e.r);
                end
                checks++;
                if (falling_edge_o !== e.f) begin
                    errors++;
                    $display("FAIL fall step %0d: got %b expected %b", e.id, falling_edge_o, e.f);
                end
                checks++;
                if ((rising_edge_o & falling_edge_o) !== '0) begin
                    errors++;
                    $display("FAIL both_high step %0d: got rise %b fall %b expected no overlap",
                             e.id, rising_edge_o, falling_edge_o);
                end
            end
        end
    end

    initial begin
        reset    = 1'b1;
        a_i      = '1;
        last_rst = 1'b1;
        last_a   = '1;
        prev     = '0;

        // Reset held with input high, then released with input still high.
        repeat (3) chk(1'b1, 4'hF, 4'h0, 4'h0);
        chk(1'b0, 4'hF, 4'hF, 4'h0);
        repeat (10) chk(1'b0, 4'hF, 4'h0, 4'h0);
        chk(1'b1, 4'hF, 4'h0, 4'h0);
        chk(1'b0, 4'hF, 4'hF, 4'h0);

        // Reset mid-operation suppresses a falling edge in progress.
        chk(1'b1, 4'h0, 4'h0, 4'h0);
        chk(1'b0, 4'h0, 4'h0, 4'h0);

        // Sequence 0,1,1,0,0 on every bit.
        chk(1'b1, 4'h0, 4'h0, 4'h0);
        chk(1'b0, 4'h0, 4'h0, 4'h0);
        chk(1'b0, 4'hF, 4'hF, 4'h0);
        chk(1'b0, 4'hF, 4'h0, 4'h0);
        chk(1'b0, 4'h0, 4'h0, 4'hF);
        chk(1'b0, 4'h0, 4'h0, 4'h0);

        // Toggle every cycle 0,1,0,1,0.
        chk(1'b1, 4'h0, 4'h0, 4'h0);
        chk(1'b0, 4'h0, 4'h0, 4'h0);
        chk(1'b0, 4'hF, 4'hF, 4'h0);
        chk(1'b0, 4'h0, 4'h0, 4'hF);
        chk(1'b0, 4'hF, 4'hF, 4'h0);
        chk(1'b0, 4'h0, 4'h0, 4'hF);

        // Independent bits: 0000 -> 0101 -> 1010.
        chk(1'b1, 4'h0, 4'h0, 4'h0);
        chk(1'b0, 4'b0000, 4'b0000, 4'b0000);
        chk(1'b0, 4'b0101, 4'b0101, 4'b0000);
        chk(1'b0, 4'b1010, 4'b1010, 4'b0101);

        // Random input after reset, checked against the model.
        chk(1'b1, 4'h0, 4'h0, 4'h0);
        for (int i = 0; i < 32; i++) begin
            step(1'b0, W'($urandom), 1'b0, '0, '0);
        end
        // Random input with occasional resets.
        for (int i = 0; i < 32; i++) begin
            step(($urandom_range(0, 7) == 0), W'($urandom), 1'b0, '0, '0);
        end

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no completion expected finish");
        $fatal(1, "timeout");
    end

endmodule
